apb_initiator: RTL and testbench

APB initiator that turns single host requests into complete APB transfers toward six peripheral ports: SETUP phase, ACCESS phase with wait states, then response. It is the requesting end of the APB interconnect and sits between the host-side bus bridge and the peripheral side. It uses the same 3-bit port codes as the interconnect routing logic: 3'b010..3'b111 select ports 1..6. It returns read data, transfer errors, and timeout errors to the host through a valid/ready response channel.

---
 rtl/apb_pkg.sv | 50 +++++
 rtl/apb_rsp_mux.sv | 27 ++
 rtl/apb_initiator.sv | 155 +++++++++++++++
 tb/tb_apb_initiator.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types, widths and port-code helpers for the APB initiator.
package apb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned PORT_W = 3;
  localparam int unsigned NPORT  = 6;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [PORT_W-1:0] PORT1 = 3'b010;
  localparam logic [PORT_W-1:0] PORT2 = 3'b011;
  localparam logic [PORT_W-1:0] PORT3 = 3'b100;
  localparam logic [PORT_W-1:0] PORT4 = 3'b101;
  localparam logic [PORT_W-1:0] PORT5 = 3'b110;
  localparam logic [PORT_W-1:0] PORT6 = 3'b111;

  typedef struct packed {
    logic              write;
    logic [PORT_W-1:0] port;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_req_t;

  function automatic logic port_valid(input logic [PORT_W-1:0] code);
    return code >= PORT1;
  endfunction

  function automatic logic [NPORT-1:0] port_onehot(input logic [PORT_W-1:0] code);
    logic [NPORT-1:0] oh;
    oh = '0;
    case (code)
      PORT1:   oh = 6'b000001;
      PORT2:   oh = 6'b000010;
      PORT3:   oh = 6'b000100;
      PORT4:   oh = 6'b001000;
      PORT5:   oh = 6'b010000;
      PORT6:   oh = 6'b100000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/apb_rsp_mux.sv
// Selects the addressed peripheral's prdata/pready/pslverr by port index.
module apb_rsp_mux
  import apb_pkg::*;
(
  input  logic [PORT_W-1:0]       idx_i,
  input  logic [NPORT*DATA_W-1:0] prdata_i,
  input  logic [NPORT-1:0]        pready_i,
  input  logic [NPORT-1:0]        pslverr_i,
  output logic [DATA_W-1:0]       rdata_o,
  output logic                    ready_o,
  output logic                    err_o
);

  always_comb begin
    rdata_o = '0;
    ready_o = 1'b0;
    err_o   = 1'b0;
    for (int i = 0; i < NPORT; i++) begin
      if (idx_i == PORT_W'(i)) begin
        rdata_o = prdata_i[i*DATA_W +: DATA_W];
        ready_o = pready_i[i];
        err_o   = pslverr_i[i];
      end
    end
  end

endmodule

// File: rtl/apb_initiator.sv
// APB initiator: one host request becomes a SETUP/ACCESS transfer to one of
// six peripheral ports, with the result returned on a valid/ready channel.
module apb_initiator
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [PORT_W-1:0]       req_port,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic [NPORT-1:0]        psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_W-1:0]       paddr,
  output logic [DATA_W-1:0]       pwdata,
  input  logic [NPORT*DATA_W-1:0] prdata,
  input  logic [NPORT-1:0]        pready,
  input  logic [NPORT-1:0]        pslverr
);

  state_e            state_q, state_d;
  apb_req_t          req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [NPORT-1:0]  psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;

  logic [DATA_W-1:0] sel_rdata;
  logic              sel_ready;
  logic              sel_err;
  logic              active;

  apb_rsp_mux u_rsp_mux (
    .idx_i     (req_q.port - PORT1),
    .prdata_i  (prdata),
    .pready_i  (pready),
    .pslverr_i (pslverr),
    .rdata_o   (sel_rdata),
    .ready_o   (sel_ready),
    .err_o     (sel_err)
  );

  // Next-state, response capture and next values of the registered APB outputs.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_d = '{write: req_write, port: req_port, addr: req_addr, wdata: req_wdata};
          cnt_d = '0;
          if (port_valid(req_port)) begin
            state_d = SETUP;
          end else begin
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // pready takes priority over a timeout landing in the same cycle
        if (sel_ready) begin
          state_d = RESP;
          err_d   = sel_err;
          rdata_d = (req_q.write || sel_err) ? '0 : sel_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    active      = (state_d == SETUP) || (state_d == ACCESS);
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    psel_d      = active ? port_onehot(req_d.port) : '0;
    penable_d   = (state_d == ACCESS);
    pwrite_d    = active && req_d.write;
    paddr_d     = active ? req_d.addr : '0;
    pwdata_d    = active ? req_d.wdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Directed bench for apb_initiator: write, waited read, invalid port,
// timeout, slave error with back-pressure, and mid-transfer reset.
module tb_apb_initiator;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [2:0]   req_port;
  logic [11:0]  req_addr;
  logic [31:0]  req_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [5:0]   psel;
  logic         penable;
  logic         pwrite;
  logic [11:0]  paddr;
  logic [31:0]  pwdata;
  logic [191:0] prdata;
  logic [5:0]   pready;
  logic [5:0]   pslverr;

  int total;
  int passed;
  int failed;
  int acc_cycles;

  apb_initiator #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_port  (req_port),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, "_psel"},    32'(psel),    32'h0);
    check({tag, "_penable"}, 32'(penable), 32'h0);
    check({tag, "_pwrite"},  32'(pwrite),  32'h0);
    check({tag, "_paddr"},   32'(paddr),   32'h0);
    check({tag, "_pwdata"},  pwdata,       32'h0);
  endtask

  task automatic issue(input logic wr, input logic [2:0] port, input logic [11:0] addr,
                       input logic [31:0] wdata);
    req_valid = 1'b1;
    req_write = wr;
    req_port  = port;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_port  = 3'b000;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  initial begin
    total = 0; passed = 0; failed = 0;
    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_port = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    prdata = '0; pready = '0; pslverr = '0;

    // Reset values
    #12;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err",   32'(rsp_err), 32'h0);
    check_idle_bus("rst");
    #2 rst = 1'b1;
    #1;
    check("rel_req_ready_low", 32'(req_ready), 32'h0);
    tick();
    check("rel_req_ready_high", 32'(req_ready), 32'h1);

    // Write to port 3, zero-wait
    pready = 6'b000100;
    issue(1'b1, 3'b100, 12'h0A4, 32'hDEADBEEF);
    check("wr_setup_psel",    32'(psel), 32'h04);
    check("wr_setup_penable", 32'(penable), 32'h0);
    check("wr_setup_paddr",   32'(paddr), 32'h0A4);
    check("wr_setup_pwdata",  pwdata, 32'hDEADBEEF);
    check("wr_setup_pwrite",  32'(pwrite), 32'h1);
    check("wr_setup_req_ready", 32'(req_ready), 32'h0);
    tick();
    check("wr_acc_psel",    32'(psel), 32'h04);
    check("wr_acc_penable", 32'(penable), 32'h1);
    check("wr_acc_paddr",   32'(paddr), 32'h0A4);
    check("wr_acc_rsp_valid", 32'(rsp_valid), 32'h0);
    tick();
    check("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    check("wr_rsp_err",   32'(rsp_err), 32'h0);
    check("wr_rsp_rdata", rsp_rdata, 32'h0);
    check_idle_bus("wr_rsp");
    tick();
    check("wr_done_rsp_valid", 32'(rsp_valid), 32'h0);
    check("wr_done_req_ready", 32'(req_ready), 32'h1);

    // Read from port 6 with 3 wait states; unselected pready/pslverr ignored
    pready = 6'b000001;
    pslverr = 6'b011111;
    prdata = {32'h12345678, 32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    issue(1'b0, 3'b111, 12'hFFC, 32'h0);
    check("rd6_setup_psel", 32'(psel), 32'h20);
    check("rd6_setup_pwrite", 32'(pwrite), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("rd6_wait_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rd6_wait_psel", 32'(psel), 32'h20);
      check("rd6_wait_paddr", 32'(paddr), 32'hFFC);
    end
    pready = 6'b100001;
    tick();
    check("rd6_rsp_valid", 32'(rsp_valid), 32'h1);
    check("rd6_rsp_rdata", rsp_rdata, 32'h12345678);
    check("rd6_rsp_err",   32'(rsp_err), 32'h0);
    pready = '0; pslverr = '0;
    tick();
    check("rd6_done_req_ready", 32'(req_ready), 32'h1);

    // Invalid port code
    issue(1'b0, 3'b001, 12'h010, 32'h0);
    check("inv_psel",      32'(psel), 32'h0);
    check("inv_rsp_valid", 32'(rsp_valid), 32'h1);
    check("inv_rsp_err",   32'(rsp_err), 32'h1);
    check("inv_rsp_rdata", rsp_rdata, 32'h0);
    tick();
    check("inv_done_rsp_valid", 32'(rsp_valid), 32'h0);
    check("inv_done_req_ready", 32'(req_ready), 32'h1);

    // Timeout on port 1
    prdata = {160'h0, 32'hA5A5A5A5};
    issue(1'b0, 3'b010, 12'h123, 32'h0);
    acc_cycles = 0;
    for (int i = 0; i < 40 && rsp_valid !== 1'b1; i++) begin
      if (penable === 1'b1) acc_cycles++;
      tick();
    end
    check("to_rsp_valid", 32'(rsp_valid), 32'h1);
    check("to_access_cycles", 32'(acc_cycles), 32'd16);
    check("to_rsp_err",   32'(rsp_err), 32'h1);
    check("to_rsp_rdata", rsp_rdata, 32'h0);
    check_idle_bus("to_rsp");
    tick();

    // Slave error on port 2 with response back-pressure
    prdata = {96'h0, 32'hCAFEF00D, 64'h0};
    pready = 6'b000010;
    pslverr = 6'b000010;
    rsp_ready = 1'b0;
    issue(1'b0, 3'b011, 12'h044, 32'h0);
    tick();
    tick();
    check("err_rsp_valid", 32'(rsp_valid), 32'h1);
    check("err_rsp_err",   32'(rsp_err), 32'h1);
    check("err_rsp_rdata", rsp_rdata, 32'h0);
    pready = '0; pslverr = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("err_hold_valid", 32'(rsp_valid), 32'h1);
      check("err_hold_err",   32'(rsp_err), 32'h1);
      check("err_hold_rdata", rsp_rdata, 32'h0);
      check("err_hold_req_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    tick();
    check("err_done_rsp_valid", 32'(rsp_valid), 32'h0);
    check("err_done_req_ready", 32'(req_ready), 32'h1);

    // Reset during ACCESS of a port-4 write
    issue(1'b1, 3'b101, 12'h300, 32'h0F0F0F0F);
    tick();
    check("mid_acc_penable", 32'(penable), 32'h1);
    check("mid_acc_psel",    32'(psel), 32'h08);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'h0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_idle_bus("mid_rst");
    tick();
    #2 rst = 1'b1;
    tick();
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("post_rst_req_ready", 32'(req_ready), 32'h1);

    // A following read on port 4 completes normally
    prdata = {64'h0, 32'h0BADCAFE, 96'h0};
    pready = 6'b001000;
    issue(1'b0, 3'b101, 12'h304, 32'h0);
    check("post_setup_psel", 32'(psel), 32'h08);
    tick();
    tick();
    check("post_rsp_valid", 32'(rsp_valid), 32'h1);
    check("post_rsp_rdata", rsp_rdata, 32'h0BADCAFE);
    check("post_rsp_err",   32'(rsp_err), 32'h0);
    tick();
    check("post_done_req_ready", 32'(req_ready), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
